// File: rtl/rcs_pkg.sv
// Shared definitions for the chunked ripple-borrow subtractor: FSM encoding and
// chunk-counter sizing.
package rcs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter width for WIDTH/CHUNK chunks; never narrower than one bit.
    function automatic int cnt_width(input int width, input int chunk);
        int n;
        n = width / chunk;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rcs_chunk.sv
// Combinational CHUNK-bit ripple of full subtractors: {bout, diff} = x - y - bin,
// built as x + ~y + ~bin with the final carry inverted into a borrow.
module rcs_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             bin,
    output logic [CHUNK-1:0] diff,
    output logic             bout
);

    always_comb begin : ripple
        logic c;
        c    = ~bin;
        diff = '0;
        for (int i = 0; i < CHUNK; i++) begin
            diff[i] = x[i] ^ ~y[i] ^ c;
            c       = (x[i] & ~y[i]) | (c & (x[i] ^ ~y[i]));
        end
        bout = ~c;
    end

endmodule

// File: rtl/rcs_sub_seq.sv
// Multi-cycle ripple-borrow subtractor d = a - b - bi, CHUNK bits per clock, with a
// start/busy/done handshake. Define RCS_OVERFLOW_EN to add the signed-overflow output ov.
module rcs_sub_seq
    import rcs_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo
`ifdef RCS_OVERFLOW_EN
    ,
    output logic             ov
`endif
);

    localparam int            N    = WIDTH / CHUNK;
    localparam int            CW   = cnt_width(WIDTH, CHUNK);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             bo_q, bo_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [CHUNK-1:0] chunk_diff;
    logic             chunk_bout;
    logic [WIDTH-1:0] shadow_nx;

`ifdef RCS_OVERFLOW_EN
    logic             ov_q, ov_d;
`endif

    // Operands shift right one chunk per RUN cycle, so the active chunk is always
    // the low CHUNK bits; on the final cycle that chunk holds the original MSBs.
    rcs_chunk #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .x   (a_q[CHUNK-1:0]),
        .y   (b_q[CHUNK-1:0]),
        .bin (borrow_q),
        .diff(chunk_diff),
        .bout(chunk_bout)
    );

    // Partial differences enter the shadow from the top; after N cycles chunk 0
    // has been pushed down to bit 0 and the shadow holds the full result.
    assign shadow_nx = (shadow_q >> CHUNK) | (WIDTH'(chunk_diff) << (WIDTH - CHUNK));

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        shadow_d = shadow_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        bo_d     = bo_q;
        cnt_d    = cnt_q;
`ifdef RCS_OVERFLOW_EN
        ov_d     = ov_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bi;
                    shadow_d = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_d      = a_q >> CHUNK;
                b_d      = b_q >> CHUNK;
                borrow_d = chunk_bout;
                shadow_d = shadow_nx;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    diff_d  = shadow_nx;
                    bo_d    = chunk_bout;
`ifdef RCS_OVERFLOW_EN
                    ov_d    = (a_q[CHUNK-1] ^ b_q[CHUNK-1]) &
                              (chunk_diff[CHUNK-1] ^ a_q[CHUNK-1]);
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            shadow_q <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bo_q     <= 1'b0;
            cnt_q    <= '0;
`ifdef RCS_OVERFLOW_EN
            ov_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            shadow_q <= shadow_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bo_q     <= bo_d;
            cnt_q    <= cnt_d;
`ifdef RCS_OVERFLOW_EN
            ov_q     <= ov_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign d    = diff_q;
    assign bo   = bo_q;
`ifdef RCS_OVERFLOW_EN
    assign ov   = ov_q;
`endif

endmodule
